// File: rtl/fifo_ptr_pkg.sv
// Shared pointer helpers for the async FIFO read/write pointer handlers.
package fifo_ptr_pkg;

  localparam int unsigned DEFAULT_N = 5;
  localparam int unsigned FN_W      = 32;

  // Gray to binary on a zero-extended value; callers cast back to their width.
  function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
    logic [FN_W-1:0] b;
    b = g;
    for (int unsigned i = 1; i < FN_W; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

  // Binary to Gray on a zero-extended value.
  function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Memory address from an n-bit Gray pointer: {g[n-1]^g[n-2], g[n-3:0]}.
  // Shared by both sides so read and write agree on entry placement.
  function automatic logic [FN_W-1:0] gray_addr(input logic [FN_W-1:0] g,
                                                input int unsigned     n);
    logic [FN_W-1:0] low;
    logic [FN_W-1:0] top;
    low = g & ((FN_W'(1) << (n - 2)) - FN_W'(1));
    top = ((g >> (n - 1)) ^ (g >> (n - 2))) & FN_W'(1);
    return low | (top << (n - 2));
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter: b[i] = ^(g >> i).
module gray_to_bin
  import fifo_ptr_pkg::*;
#(
  parameter int unsigned n = DEFAULT_N
) (
  input  logic [n-1:0] g,
  output logic [n-1:0] b
);

  // Each binary bit is the parity of the Gray bits at and above it.
  for (genvar i = 0; i < int'(n); i++) begin : g_bit
    assign b[i] = ^(g >> i);
  end

endmodule

// File: rtl/rptr_handler.sv
// Read-side pointer and status flags of the dual-clock FIFO (read clock domain).
module rptr_handler
  import fifo_ptr_pkg::*;
#(
  parameter int unsigned n         = DEFAULT_N,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic         clk,
  input  logic         rreset,
  input  logic         rinc,
  input  logic         rclr_err,
  input  logic [n-1:0] rq2wptr,
  output logic [n-2:0] rdaddr,
  output logic [n-1:0] rptr,
  output logic         rempty,
  output logic         ralmost_empty,
  output logic [n-1:0] rlevel,
  output logic         runderflow
);

  localparam int unsigned AW = n - 1;

  logic [n-1:0]  rptr_q, rptr_d;
  logic [AW-1:0] rdaddr_q, rdaddr_d;
  logic          rempty_q, rempty_d;
  logic          ralmost_empty_q, ralmost_empty_d;
  logic [n-1:0]  rlevel_q, rlevel_d;
  logic          runderflow_q, runderflow_d;

  logic [n-1:0]  rbin;
  logic [n-1:0]  wbin;
  logic [n-1:0]  rbin_next;

  gray_to_bin #(.n(n)) u_rbin (.g(rptr_q),  .b(rbin));
  gray_to_bin #(.n(n)) u_wbin (.g(rq2wptr), .b(wbin));

  // Next pointer, address and flags; all flags derive from the post-read pointer.
  always_comb begin
    rbin_next       = rbin + n'(rinc & ~rempty_q);
    rptr_d          = rbin_next ^ (rbin_next >> 1);
    rdaddr_d        = AW'(gray_addr(FN_W'(rptr_d), n));
    rempty_d        = (rptr_d == rq2wptr);
    rlevel_d        = wbin - rbin_next;
    ralmost_empty_d = (rlevel_d <= n'(AE_THRESH));
    runderflow_d    = (runderflow_q & ~rclr_err) | (rinc & rempty_q);
  end

  // State registers; async reset leaves the FIFO reported as empty.
  always_ff @(posedge clk or posedge rreset) begin
    if (rreset) begin
      rptr_q          <= '0;
      rdaddr_q        <= '0;
      rempty_q        <= 1'b1;
      ralmost_empty_q <= 1'b1;
      rlevel_q        <= '0;
      runderflow_q    <= 1'b0;
    end else begin
      rptr_q          <= rptr_d;
      rdaddr_q        <= rdaddr_d;
      rempty_q        <= rempty_d;
      ralmost_empty_q <= ralmost_empty_d;
      rlevel_q        <= rlevel_d;
      runderflow_q    <= runderflow_d;
    end
  end

  assign rptr          = rptr_q;
  assign rdaddr        = rdaddr_q;
  assign rempty        = rempty_q;
  assign ralmost_empty = ralmost_empty_q;
  assign rlevel        = rlevel_q;
  assign runderflow    = runderflow_q;

endmodule

// File: tb/tb_rptr_handler.sv
// Scoreboard bench for rptr_handler: stimulus pushes expected state, monitor pops and compares.
module tb_rptr_handler;

  localparam int N     = 5;
  localparam int DEPTH = 16;
  localparam int AE    = 2;
  localparam int PMASK = (1 << N) - 1;
  localparam int AMASK = DEPTH - 1;

  logic         clk = 1'b0;
  logic         rreset;
  logic         rinc;
  logic         rclr_err;
  logic [N-1:0] rq2wptr;
  logic [N-2:0] rdaddr;
  logic [N-1:0] rptr;
  logic         rempty;
  logic         ralmost_empty;
  logic [N-1:0] rlevel;
  logic         runderflow;

  rptr_handler #(.n(N), .AE_THRESH(AE)) dut (
    .clk(clk), .rreset(rreset), .rinc(rinc), .rclr_err(rclr_err),
    .rq2wptr(rq2wptr), .rdaddr(rdaddr), .rptr(rptr), .rempty(rempty),
    .ralmost_empty(ralmost_empty), .rlevel(rlevel), .runderflow(runderflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ptr;
    int addr;
    int empty;
    int ae;
    int level;
    int uf;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: total words read / written since reset, and the sticky error.
  int   m_rd = 0;
  int   m_w  = 0;
  bit   m_uf = 1'b0;
  bit   prev_valid = 1'b0;
  int   prev_ptr = 0;

  function automatic int gray(input int v);
    return v ^ (v >> 1);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One read-clock cycle of stimulus; wtotal is the total words written so far.
  task automatic step(input bit ri, input bit clr, input int wtotal);
    exp_t e;
    bit   was_empty;
    @(negedge clk);
    rinc     = ri;
    rclr_err = clr;
    rq2wptr  = N'(gray(wtotal & PMASK));
    was_empty = ((m_w - m_rd) == 0);
    if (ri && !was_empty) m_rd++;
    m_uf = (m_uf && !clr) || (ri && was_empty);
    m_w  = wtotal;
    e.level = m_w - m_rd;
    e.ptr   = gray(m_rd & PMASK);
    e.addr  = gray(m_rd & AMASK);
    e.empty = (e.level == 0) ? 1 : 0;
    e.ae    = (e.level <= AE) ? 1 : 0;
    e.uf    = m_uf ? 1 : 0;
    q.push_back(e);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rptr"},   int'(rptr), 0);
    check({tag, "_rdaddr"}, int'(rdaddr), 0);
    check({tag, "_rempty"}, int'(rempty), 1);
    check({tag, "_ae"},     int'(ralmost_empty), 1);
    check({tag, "_rlevel"}, int'(rlevel), 0);
    check({tag, "_uf"},     int'(runderflow), 0);
  endtask

  // Asynchronous reset asserted between edges, released at the following negedge.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    rreset = 1'b1;
    #1;
    check_reset_vals(tag);
    @(negedge clk);
    rinc     = 1'b0;
    rclr_err = 1'b0;
    rq2wptr  = '0;
    rreset   = 1'b0;
    m_rd = 0;
    m_w  = 0;
    m_uf = 1'b0;
    prev_valid = 1'b0;
    step(1'b0, 1'b0, 0);
  endtask

  // Monitor: every edge the DUT presents a new state; compare it with the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rreset && q.size() > 0) begin
        e = q.pop_front();
        check("rptr",   int'(rptr), e.ptr);
        check("rdaddr", int'(rdaddr), e.addr);
        check("rempty", int'(rempty), e.empty);
        check("ralmost_empty", int'(ralmost_empty), e.ae);
        check("rlevel", int'(rlevel), e.level);
        check("runderflow", int'(runderflow), e.uf);
        check("empty_iff_level0", int'(rempty), (rlevel == '0) ? 1 : 0);
        if (prev_valid) check("rptr_onebit", ($countones(rptr ^ N'(prev_ptr)) <= 1) ? 1 : 0, 1);
        prev_ptr   = int'(rptr);
        prev_valid = 1'b1;
      end
    end
  end

  initial begin
    int w;
    rreset   = 1'b1;
    rinc     = 1'b0;
    rclr_err = 1'b0;
    rq2wptr  = '0;
    #2;
    check_reset_vals("init_reset");
    repeat (2) @(negedge clk);
    rreset = 1'b0;
    step(1'b0, 1'b0, 0);

    // Three entries, then drain them.
    step(1'b0, 1'b0, 3);
    repeat (3) step(1'b1, 1'b0, 3);

    // Underflow: sticky, cleared by rclr_err, set wins over clear.
    step(1'b1, 1'b0, 3);
    step(1'b0, 1'b0, 3);
    step(1'b0, 1'b1, 3);
    step(1'b1, 1'b1, 3);
    step(1'b0, 1'b1, 3);

    // Mid-operation reset, then full FIFO drained to wrap.
    do_reset("mid_reset");
    step(1'b0, 1'b0, DEPTH);
    repeat (DEPTH) step(1'b1, 1'b0, DEPTH);
    step(1'b0, 1'b0, DEPTH);

    // Write burst, then reads keeping pace with writes.
    do_reset("burst_reset");
    step(1'b0, 1'b0, 4);
    for (int k = 5; k < 12; k++) step(1'b1, 1'b0, k);

    // Randomised traffic with a monotonic write pointer, including wrap.
    w = m_w;
    for (int k = 0; k < 3000; k++) begin
      w = w + int'($urandom_range(0, 3));
      if (w > m_rd + DEPTH) w = m_rd + DEPTH;
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0), w);
    end

    @(negedge clk);
    rinc = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
